// File: rtl/uart_pkg.sv
// Shared UART definitions: line FSM states and the bit-period helper.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   function automatic int baud_period(int clk_khz, int bods);
      return (clk_khz * 1000) / bods;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock word FIFO; full/empty come straight from the registered count.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full && !rst;
   assign do_pop  = pop && !empty && !rst;
   assign rdata   = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + AW'(1);
         end
         if (do_pop) begin
            rptr <= rptr + AW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + ONE;
            2'b01:   count <= count - ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed frame serializer with optional even parity.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLK_KHZ     = 100000,
   parameter int BODS        = 9600,
   parameter int DATA_AMOUNT = 8,
   parameter int FIFO_DEPTH  = 8,
   parameter int PARITY_EN   = 0
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          valid_i,
   input  logic [DATA_AMOUNT-1:0]        data_i,
   output logic                          ready_o,
   output logic                          tx_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o
);

   localparam int PERIOD = baud_period(CLK_KHZ, BODS);
   localparam int CW     = $clog2(PERIOD + 1);
   localparam int BW     = $clog2(DATA_AMOUNT + 1);

   uart_state_t             state;
   logic [CW-1:0]           baud;
   logic [BW-1:0]           bit_idx;
   logic [DATA_AMOUNT-1:0]  shift;
   logic                    par;
   logic [DATA_AMOUNT-1:0]  head;
   logic                    full;
   logic                    empty;
   logic                    pop;
   logic                    tc;
   logic                    line;

   uart_sync_fifo #(
      .WIDTH (DATA_AMOUNT),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (valid_i),
      .wdata (data_i),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count_o)
   );

   assign ready_o = !full;
   assign tc      = (baud == CW'(PERIOD - 1));
   assign pop     = !empty && ((state == IDLE) || (state == STOP && tc));

   // tx_o lags the state by one edge, so every bit keeps a full period
   always_comb begin
      line = 1'b1;
      unique case (state)
         START:   line = 1'b0;
         DATA:    line = shift[0];
         PARITY:  line = par;
         default: line = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
         par     <= 1'b0;
         tx_o    <= 1'b1;
         busy_o  <= 1'b0;
      end else begin
         tx_o <= line;
         unique case (state)
            IDLE: begin
               baud <= '0;
               if (!empty) begin
                  state  <= START;
                  shift  <= head;
                  par    <= ^head;
                  busy_o <= 1'b1;
               end
            end
            START: begin
               if (tc) begin
                  baud    <= '0;
                  bit_idx <= '0;
                  state   <= DATA;
               end else begin
                  baud <= baud + CW'(1);
               end
            end
            DATA: begin
               if (tc) begin
                  baud  <= '0;
                  shift <= shift >> 1;
                  if (bit_idx == BW'(DATA_AMOUNT - 1)) begin
                     state <= (PARITY_EN != 0) ? PARITY : STOP;
                  end else begin
                     bit_idx <= bit_idx + BW'(1);
                  end
               end else begin
                  baud <= baud + CW'(1);
               end
            end
            PARITY: begin
               if (tc) begin
                  baud  <= '0;
                  state <= STOP;
               end else begin
                  baud <= baud + CW'(1);
               end
            end
            STOP: begin
               if (tc) begin
                  baud <= '0;
                  // back-to-back frames: next start bit follows the stop bit
                  if (!empty) begin
                     state <= START;
                     shift <= head;
                     par   <= ^head;
                  end else begin
                     state  <= IDLE;
                     busy_o <= 1'b0;
                  end
               end else begin
                  baud <= baud + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: frame-timer reference model plus directed tables.
module tb_uart_tx_buffered;

   localparam int CLK_KHZ = 1000;
   localparam int BODS    = 100000;
   localparam int DW      = 8;
   localparam int DEPTH   = 8;
   localparam int PER     = CLK_KHZ * 1000 / BODS;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid;
   logic [7:0] data;
   logic [1:0] ready;
   logic [1:0] tx;
   logic [1:0] busy;
   logic [3:0] cnt0;
   logic [3:0] cnt1;

   always #5 clk = ~clk;

   uart_tx_buffered #(
      .CLK_KHZ(CLK_KHZ), .BODS(BODS), .DATA_AMOUNT(DW),
      .FIFO_DEPTH(DEPTH), .PARITY_EN(0)
   ) dut0 (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data),
      .ready_o(ready[0]), .tx_o(tx[0]), .busy_o(busy[0]), .count_o(cnt0)
   );

   uart_tx_buffered #(
      .CLK_KHZ(CLK_KHZ), .BODS(BODS), .DATA_AMOUNT(DW),
      .FIFO_DEPTH(DEPTH), .PARITY_EN(1)
   ) dut1 (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .data_i(data),
      .ready_o(ready[1]), .tx_o(tx[1]), .busy_o(busy[1]), .count_o(cnt1)
   );

   int checks   = 0;
   int failures = 0;

   // reference: buffer contents plus a countdown of the frame on the line
   int         m_cnt [2];
   int         m_head[2];
   int         m_rem [2];
   logic [7:0] m_buf [2][DEPTH];
   logic [7:0] m_cur [2];
   logic       m_txn [2];
   logic       m_txe [2];

   typedef struct {
      int          par;
      logic [7:0]  word;
      int          nbits;
      logic [0:10] seq;
   } vec_t;

   vec_t vecs[6];

   function automatic int frame_len(int d);
      return (DW + 2 + d) * PER;
   endfunction

   function automatic logic frame_bit(int d, logic [7:0] w, int k);
      if (k == 0) return 1'b0;
      if (k <= DW) return w[k-1];
      if (d == 1 && k == DW + 1) return ^w;
      return 1'b1;
   endfunction

   function automatic logic [3:0] cnt_of(int d);
      return (d == 0) ? cnt0 : cnt1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step(input int d);
      logic push;
      logic pop;
      if (rst) begin
         m_cnt[d]  = 0;
         m_head[d] = 0;
         m_rem[d]  = 0;
         m_txn[d]  = 1'b1;
         m_txe[d]  = 1'b1;
         return;
      end
      m_txe[d] = m_txn[d];
      push = valid && (m_cnt[d] < DEPTH);
      pop  = 1'b0;
      if (m_rem[d] == 0) begin
         pop = (m_cnt[d] > 0);
      end else begin
         m_rem[d]--;
         if (m_rem[d] == 0) pop = (m_cnt[d] > 0);
      end
      if (push) m_buf[d][(m_head[d] + m_cnt[d]) % DEPTH] = data;
      if (pop) begin
         m_cur[d]  = m_buf[d][m_head[d]];
         m_head[d] = (m_head[d] + 1) % DEPTH;
         m_rem[d]  = frame_len(d);
      end
      m_cnt[d] = m_cnt[d] + int'(push) - int'(pop);
      m_txn[d] = (m_rem[d] > 0)
               ? frame_bit(d, m_cur[d], (frame_len(d) - m_rem[d]) / PER)
               : 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      step(0);
      step(1);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("tx%0d", d), 32'(tx[d]), 32'(m_txe[d]));
         chk($sformatf("busy%0d", d), 32'(busy[d]), 32'(m_rem[d] > 0));
         chk($sformatf("count%0d", d), 32'(cnt_of(d)), 32'(m_cnt[d]));
         chk($sformatf("ready%0d", d), 32'(ready[d]), 32'(m_cnt[d] < DEPTH));
      end
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while ((busy != 2'b00 || cnt0 != 0 || cnt1 != 0) && n < limit) begin
         tick();
         n++;
      end
      chk("wait_idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      vecs[0] = '{0, 8'h72, 10, 11'b00100111011};
      vecs[1] = '{1, 8'hA1, 11, 11'b01000010111};
      vecs[2] = '{0, 8'hFF, 10, 11'b01111111111};
      vecs[3] = '{1, 8'h00, 11, 11'b00000000001};
      vecs[4] = '{1, 8'h72, 11, 11'b00100111001};
      vecs[5] = '{0, 8'h01, 10, 11'b01000000011};

      rst   = 1'b1;
      valid = 1'b0;
      data  = 8'h00;
      repeat (2) tick();
      valid = 1'b1;
      data  = 8'h5A;
      tick();
      chk("reset_tx", 32'(tx), 32'b11);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_count", 32'(cnt0), 32'd0);
      chk("reset_ready", 32'(ready), 32'b11);
      valid = 1'b0;
      rst   = 1'b0;
      repeat (3) tick();
      chk("push_in_reset_dropped", 32'(cnt0), 32'd0);

      for (int i = 0; i < 6; i++) begin
         wait_idle(40 * PER);
         data  = vecs[i].word;
         valid = 1'b1;
         tick();
         valid = 1'b0;
         tick();
         chk($sformatf("lat_hold_v%0d", i), 32'(tx[vecs[i].par]), 32'd1);
         tick();
         chk($sformatf("lat_fall_v%0d", i), 32'(tx[vecs[i].par]), 32'd0);
         for (int k = 0; k < vecs[i].nbits; k++) begin
            repeat ((k == 0) ? PER / 2 : PER) tick();
            chk($sformatf("line_v%0d_b%0d", i, k),
                32'(tx[vecs[i].par]), 32'(vecs[i].seq[k]));
         end
      end

      wait_idle(40 * PER);
      valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         data = 8'h10 + 8'(i);
         tick();
      end
      chk("b2b_count0", 32'(cnt0), 32'd8);
      chk("b2b_count1", 32'(cnt1), 32'd8);
      chk("b2b_ready", 32'(ready), 32'd0);
      data = 8'hEE;
      tick();
      chk("full_push_refused", 32'(cnt0), 32'd8);
      valid = 1'b0;
      wait_idle(10 * 12 * PER);

      valid = 1'b1;
      data  = 8'h72;
      tick();
      for (int i = 0; i < 3; i++) begin
         data = 8'hC0 + 8'(i);
         tick();
      end
      valid = 1'b0;
      repeat (3 * PER) tick();
      rst = 1'b1;
      tick();
      chk("abort_tx", 32'(tx), 32'b11);
      chk("abort_count", 32'(cnt0), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      repeat (15 * PER) tick();
      chk("abort_no_frames", 32'(tx), 32'b11);

      for (int i = 0; i < 4000; i++) begin
         valid = ($urandom_range(0, 2) == 0);
         data  = 8'($urandom);
         rst   = ($urandom_range(0, 999) == 0);
         tick();
      end
      valid = 1'b0;
      rst   = 1'b0;
      wait_idle(12 * 12 * PER);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
